// File: rtl/wb_select_stage_if.sv
// Handshake and datapath bundle between the MEM/WB register, the
// writeback-select stage and the register file write port.
interface wb_select_stage_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 6,
    parameter int SELW  = 3,
    parameter int CNTW  = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NSRC*WIDTH-1:0]   in_src;
    logic [SELW-1:0]         in_sel;
    logic                    in_link;
    logic [WIDTH-1:0]        in_pc;
    logic [2:0]              in_ld_mode;
    logic [1:0]              in_addr_lo;
    logic                    in_we;
    logic [4:0]              in_dst;
    logic                    flush;
    logic                    wb_ready;
    logic                    wb_valid;
    logic                    wb_we;
    logic [4:0]              wb_dst;
    logic [WIDTH-1:0]        wb_data;
    logic                    sel_err;
    logic                    align_err;
    logic [CNTW-1:0]         wb_count;

    // Stage side: consumes the pipeline beat, produces the writeback beat.
    modport slave (
        input  in_valid, in_src, in_sel, in_link, in_pc, in_ld_mode,
               in_addr_lo, in_we, in_dst, flush, wb_ready,
        output in_ready, wb_valid, wb_we, wb_dst, wb_data, sel_err,
               align_err, wb_count
    );

    // Environment side: drives the beat and the register-file ready.
    modport master (
        output in_valid, in_src, in_sel, in_link, in_pc, in_ld_mode,
               in_addr_lo, in_we, in_dst, flush, wb_ready,
        input  in_ready, wb_valid, wb_we, wb_dst, wb_data, sel_err,
               align_err, wb_count
    );
endinterface

// File: rtl/wb_select_stage.sv
// Writeback-select stage: picks a result channel or the link address,
// extends load data, suppresses $0 writes and holds the result in a
// one-entry output register with valid/ready, flush and a retire counter.
module wb_select_stage #(
    parameter int WIDTH       = 32,
    parameter int NSRC        = 6,
    parameter int SELW        = 3,
    parameter int LOAD_SRC    = 2,
    parameter int LINK_OFFSET = 8,
    parameter int CNTW        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    wb_select_stage_if.slave bus
);
    localparam logic [SELW:0]   NSRC_L = (SELW+1)'(NSRC);
    localparam logic [SELW-1:0] LOAD_L = SELW'(LOAD_SRC);

    // Byte sign/zero extension to the datapath width.
    function automatic logic [WIDTH-1:0] ext_byte(input logic [7:0] v, input logic sgn);
        logic signed [7:0]       s8;
        logic signed [WIDTH-1:0] sw;
        s8 = signed'(v);
        sw = s8;
        return sgn ? sw : {{(WIDTH-8){1'b0}}, v};
    endfunction

    // Halfword sign/zero extension to the datapath width.
    function automatic logic [WIDTH-1:0] ext_half(input logic [15:0] v, input logic sgn);
        logic signed [15:0]      s16;
        logic signed [WIDTH-1:0] sw;
        s16 = signed'(v);
        sw  = s16;
        return sgn ? sw : {{(WIDTH-16){1'b0}}, v};
    endfunction

    logic [WIDTH-1:0] chan_word;
    logic [WIDTH-1:0] ld_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] ld_ext;
    logic             ld_misalign;
    logic             sel_bad;
    logic             is_load;
    logic             accept;

    logic             valid_q;
    logic             we_q, we_d;
    logic [4:0]       dst_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sel_err_q, sel_err_d;
    logic             align_err_q, align_err_d;
    logic [CNTW-1:0]  count_q;

    assign ld_word = bus.in_src[LOAD_SRC*WIDTH +: WIDTH];
    assign ld_half = bus.in_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

    // Multiplex the legal channels; illegal codes fall through to zero.
    always_comb begin
        chan_word = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.in_sel == SELW'(k)) chan_word = bus.in_src[k*WIDTH +: WIDTH];
        end
    end

    // Pick the little-endian byte lane addressed by the low address bits.
    always_comb begin
        case (bus.in_addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
    end

    // Extend by load mode and flag offsets that the access size cannot use.
    always_comb begin
        ld_ext      = ld_word;
        ld_misalign = 1'b0;
        case (bus.in_ld_mode)
            3'b001:  ld_ext = ext_byte(ld_byte, 1'b1);
            3'b010:  ld_ext = ext_byte(ld_byte, 1'b0);
            3'b011: begin
                ld_ext      = ext_half(ld_half, 1'b1);
                ld_misalign = bus.in_addr_lo[0];
            end
            3'b100: begin
                ld_ext      = ext_half(ld_half, 1'b0);
                ld_misalign = bus.in_addr_lo[0];
            end
            default: ld_misalign = (bus.in_addr_lo != 2'd0);
        endcase
    end

    // Result priority: link address, illegal select, load, plain channel.
    always_comb begin
        sel_bad     = ({1'b0, bus.in_sel} >= NSRC_L);
        is_load     = !bus.in_link && !sel_bad && (bus.in_sel == LOAD_L);
        sel_err_d   = !bus.in_link && sel_bad;
        align_err_d = is_load && ld_misalign;
        if (bus.in_link)  data_d = bus.in_pc + WIDTH'(LINK_OFFSET);
        else if (sel_bad) data_d = '0;
        else if (is_load) data_d = ld_ext;
        else              data_d = chan_word;
        we_d = bus.in_we && (bus.in_dst != 5'd0) && !sel_err_d && !align_err_d;
    end

    assign bus.in_ready = !valid_q || bus.wb_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Output register: flush drops everything, otherwise capture or drain;
    // a retired write counts only if that edge is not flushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            dst_q       <= '0;
            data_q      <= '0;
            sel_err_q   <= 1'b0;
            align_err_q <= 1'b0;
            count_q     <= '0;
        end else begin
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q     <= 1'b1;
                we_q        <= we_d;
                dst_q       <= bus.in_dst;
                data_q      <= data_d;
                sel_err_q   <= sel_err_d;
                align_err_q <= align_err_d;
            end else if (valid_q && bus.wb_ready) begin
                valid_q <= 1'b0;
            end
            if (valid_q && bus.wb_ready && we_q && !bus.flush)
                count_q <= count_q + CNTW'(1);
        end
    end

    assign bus.wb_valid  = valid_q;
    assign bus.wb_we     = we_q;
    assign bus.wb_dst    = dst_q;
    assign bus.wb_data   = data_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.align_err = align_err_q;
    assign bus.wb_count  = count_q;
endmodule
